output_layer_streamer: RTL and testbench

//  Transmit side of the max-finder interface. Captures the NN4 parallel output-layer scores.

---
 rtl/output_layer_streamer_if.sv | 28 ++
 rtl/output_layer_streamer.sv | 155 +++++++++++++++
 tb/tb_output_layer_streamer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_layer_streamer_if.sv
// Handshake bundle between output_layer_streamer (master) and max_finder (slave).
// The streamer drives the clear pulse and the score stream.
// max_finder answers with found_max and predicted_output.
interface output_layer_streamer_if #(
    parameter int INDATA_WIDTH = 47
);
    logic                    max_finder_reset_allowed;
    logic                    start_maxfinder;
    logic [INDATA_WIDTH-1:0] input_data;
    logic                    found_max;
    logic [3:0]              predicted_output;

    modport master (
        output max_finder_reset_allowed,
        output start_maxfinder,
        output input_data,
        input  found_max,
        input  predicted_output
    );

    modport slave (
        input  max_finder_reset_allowed,
        input  start_maxfinder,
        input  input_data,
        output found_max,
        output predicted_output
    );
endinterface

// File: rtl/output_layer_streamer.sv
// output_layer_streamer: captures one frame of output-layer scores and clears max_finder.
// It then streams the scores one per clock, index 0 first.
// Finally it returns max_finder's answer as a one-cycle classification result.
// A missing found_max is reported as class 4'hF with timeout_err set.
module output_layer_streamer #(
    parameter int INDATA_WIDTH = 47,
    parameter int NN4          = 10,
    parameter int WAIT_LIMIT   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        layer_done,
    input  logic [NN4*INDATA_WIDTH-1:0] layer_data,
    output_layer_streamer_if.master     mf,
    output logic                        busy,
    output logic                        result_valid,
    output logic [3:0]                  result_class,
    output logic                        timeout_err,
    output logic                        overrun_err
);

    localparam int CNT_W  = $clog2(NN4 + 1);
    localparam int IDX_W  = $clog2(NN4);
    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic [INDATA_WIDTH-1:0] r_scores [NN4];
    logic [3:0]              r_result_class;
    logic                    r_timeout_err;
    logic                    r_overrun_err;

    logic                    w_accept;
    logic                    w_last_word;
    logic                    w_timeout;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_clear;
    logic                    w_start;
    logic [INDATA_WIDTH-1:0] w_data;
    logic                    w_busy;
    logic                    w_result_valid;

    // A frame is only accepted while idle; anything else is an overrun.
    assign w_accept    = (r_state == S_IDLE) && layer_done;
    assign w_last_word = (r_cnt == CNT_W'(NN4 - 1));
    assign w_timeout   = (r_wait_cnt == WAIT_W'(WAIT_LIMIT - 1)) && !mf.found_max;
    assign w_idx       = r_cnt[IDX_W-1:0];

    // State register; an asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every clocked block uses non-blocking assignments so all flops update together.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: IDLE -> CLEAR -> STREAM (NN4 cycles) -> WAIT -> DONE -> IDLE.
    always_comb begin
        // NOTE: default first, so no path through the case leaves it unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (layer_done) w_next_state = S_CLEAR;
            S_CLEAR:  w_next_state = S_STREAM;
            S_STREAM: if (w_last_word) w_next_state = S_WAIT;
            S_WAIT:   if (mf.found_max || w_timeout) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode from registered state/counter, so outputs only move just after posedge.
    always_comb begin
        w_clear        = 1'b0;
        w_start        = 1'b0;
        w_data         = '0;
        w_result_valid = 1'b0;
        w_busy         = (r_state != S_IDLE);
        case (r_state)
            S_CLEAR:  w_clear = 1'b1;
            S_STREAM: begin
                w_start = 1'b1;
                w_data  = r_scores[w_idx];
            end
            S_DONE:   w_result_valid = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: frame capture, stream/wait counters, result and error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_wait_cnt     <= '0;
            r_result_class <= '0;
            r_timeout_err  <= 1'b0;
            r_overrun_err  <= 1'b0;
            // NOTE: this is a small flop array, not a RAM, so it is reset to keep input_data free of X.
            for (int i = 0; i < NN4; i++) begin
                r_scores[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < NN4; i++) begin
                    r_scores[i] <= layer_data[i*INDATA_WIDTH +: INDATA_WIDTH];
                end
                r_timeout_err <= 1'b0;
            end

            if (layer_done && (r_state != S_IDLE)) begin
                r_overrun_err <= 1'b1;
            end

            // Counter runs every STREAM cycle with no stall; it parks at zero elsewhere.
            if (r_state == S_STREAM) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                if (mf.found_max) begin
                    r_result_class <= mf.predicted_output;
                end else if (w_timeout) begin
                    r_result_class <= 4'hF;
                    r_timeout_err  <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign mf.max_finder_reset_allowed = w_clear;
    assign mf.start_maxfinder          = w_start;
    assign mf.input_data               = w_data;
    assign busy                        = w_busy;
    assign result_valid                = w_result_valid;
    assign result_class                = r_result_class;
    assign timeout_err                 = r_timeout_err;
    assign overrun_err                 = r_overrun_err;

endmodule

// File: tb/tb_output_layer_streamer.sv
// Testbench for output_layer_streamer with a behavioural max_finder on the slave side.
// Expected classifications are pushed to a scoreboard when a frame is driven.
// They are popped and compared when result_valid appears.
module tb_output_layer_streamer;

    localparam int W      = 47;
    localparam int NN4    = 10;
    localparam int WL     = 4;
    localparam int BUDGET = 40;

    typedef struct packed {
        logic [3:0] cls;
        logic       to;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             layer_done = 1'b0;
    logic [NN4*W-1:0] layer_data = '0;
    logic             busy;
    logic             result_valid;
    logic [3:0]       result_class;
    logic             timeout_err;
    logic             overrun_err;

    int               errors = 0;
    int               checks = 0;
    exp_t             sb[$];
    logic [W-1:0]     cur [NN4];

    output_layer_streamer_if #(.INDATA_WIDTH(W)) mf_if ();

    output_layer_streamer #(
        .INDATA_WIDTH(W),
        .NN4         (NN4),
        .WAIT_LIMIT  (WL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .layer_done  (layer_done),
        .layer_data  (layer_data),
        .mf          (mf_if),
        .busy        (busy),
        .result_valid(result_valid),
        .result_class(result_class),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    // Behavioural max_finder: clears on the pulse, keeps the first strict maximum,
    // raises found_max for one cycle after the NN4-th word. mute suppresses found_max.
    logic         mute = 1'b0;
    logic [W-1:0] m_max;
    logic [3:0]   m_idx;
    logic [4:0]   m_cnt;
    logic         m_found;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_max   <= '0;
            m_idx   <= '0;
            m_cnt   <= '0;
            m_found <= 1'b0;
        end else if (mf_if.max_finder_reset_allowed) begin
            m_max   <= '0;
            m_idx   <= '0;
            m_cnt   <= '0;
            m_found <= 1'b0;
        end else begin
            m_found <= 1'b0;
            if (mf_if.start_maxfinder) begin
                if (m_cnt == 5'd0 || mf_if.input_data > m_max) begin
                    m_max <= mf_if.input_data;
                    m_idx <= m_cnt[3:0];
                end
                m_cnt <= m_cnt + 5'd1;
                if (m_cnt == 5'(NN4 - 1) && !mute) m_found <= 1'b1;
            end
        end
    end

    assign mf_if.found_max        = m_found;
    assign mf_if.predicted_output = m_idx;

    // Monitor on the falling edge: counts clear pulses and stream words, logs the words.
    int           n_clear = 0;
    int           n_start = 0;
    int           n_bad_data = 0;
    logic [W-1:0] words[$];

    always @(negedge clk) begin
        if (mf_if.max_finder_reset_allowed) n_clear++;
        if (mf_if.start_maxfinder) begin
            n_start++;
            words.push_back(mf_if.input_data);
        end else if (mf_if.input_data !== '0) begin
            n_bad_data++;
        end
    end

    // Step to just after the next falling edge: outputs are stable, inputs may change.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_argmax();
        int b = 0;
        for (int i = 1; i < NN4; i++) begin
            if (cur[i] > cur[b]) b = i;
        end
        return 4'(b);
    endfunction

    // Present cur[] for one cycle with layer_done and record the expected outcome.
    // Returns in the CLEAR cycle; layer_data is scrambled afterwards.
    task automatic send_frame(input logic expect_timeout);
        for (int i = 0; i < NN4; i++) layer_data[i*W +: W] = cur[i];
        layer_done = 1'b1;
        if (expect_timeout) sb.push_back(exp_t'{cls: 4'hF, to: 1'b1});
        else                sb.push_back(exp_t'{cls: ref_argmax(), to: 1'b0});
        tick();
        layer_done = 1'b0;
        for (int i = 0; i < NN4; i++) layer_data[i*W +: W] = W'({$urandom(), $urandom()});
    endtask

    // Wait (bounded) for result_valid; lat is the cycle count after CLEAR, 0 if it never came.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            tick();
            if (result_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({busy, result_valid, result_class, timeout_err, overrun_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {busy, result_valid, result_class, timeout_err, overrun_err});
        end
        checks++;
        if ({mf_if.max_finder_reset_allowed, mf_if.start_maxfinder} !== 2'b00 || mf_if.input_data !== '0) begin
            errors++;
            $display("FAIL reset_mf: clr=%b start=%b data=%h expected all 0",
                     mf_if.max_finder_reset_allowed, mf_if.start_maxfinder, mf_if.input_data);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ascending();
        int   lat;
        exp_t e;
        for (int i = 0; i < NN4; i++) cur[i] = W'(i * 100);
        send_frame(1'b0);
        checks++;
        if ({busy, mf_if.max_finder_reset_allowed, mf_if.start_maxfinder} !== 3'b110) begin
            errors++;
            $display("FAIL clear_cycle: busy/clr/start=%b expected 110",
                     {busy, mf_if.max_finder_reset_allowed, mf_if.start_maxfinder});
        end
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== NN4 + 2) begin
            errors++;
            $display("FAIL asc_latency: got %0d expected %0d", lat, NN4 + 2);
        end
        checks++;
        if (result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL asc_result: class=%h to=%b expected class=%h to=%b",
                     result_class, timeout_err, e.cls, e.to);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_class !== e.cls) begin
            errors++;
            $display("FAIL asc_pulse: valid=%b busy=%b class=%h expected 0 0 %h",
                     result_valid, busy, result_class, e.cls);
        end
    endtask

    task automatic test_order();
        int   lat;
        int   base_start;
        int   base_w;
        exp_t e;
        for (int i = 0; i < NN4; i++) cur[i] = W'(5);
        cur[3]     = 47'h7FFF_FFFF_FFFF;
        base_start = n_start;
        base_w     = words.size();
        send_frame(1'b0);
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat == 0 || result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL order_result: lat=%0d class=%h to=%b expected class=%h to=%b",
                     lat, result_class, timeout_err, e.cls, e.to);
        end
        checks++;
        if (n_start - base_start !== NN4) begin
            errors++;
            $display("FAIL order_count: got %0d start cycles expected %0d", n_start - base_start, NN4);
        end
        for (int i = 0; i < NN4; i++) begin
            checks++;
            if (base_w + i >= words.size() || words[base_w + i] !== cur[i]) begin
                errors++;
                $display("FAIL order_word%0d: got %h expected %h", i,
                         (base_w + i < words.size()) ? words[base_w + i] : '0, cur[i]);
            end
        end
        checks++;
        if (n_bad_data !== 0) begin
            errors++;
            $display("FAIL idle_data: %0d cycles with nonzero input_data outside STREAM, expected 0", n_bad_data);
        end
        tick();
    endtask

    task automatic test_overrun();
        int   lat;
        exp_t e;
        for (int i = 0; i < NN4; i++) cur[i] = W'(1000 - i * 7);
        checks++;
        if (overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b expected 0", overrun_err);
        end
        send_frame(1'b0);
        repeat (3) tick();
        for (int i = 0; i < NN4; i++) layer_data[i*W +: W] = (i == NN4 - 1) ? 47'h7FFF_FFFF_FFFF : '0;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat == 0 || result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL overrun_result: lat=%0d class=%h to=%b expected class=%h to=%b",
                     lat, result_class, timeout_err, e.cls, e.to);
        end
        checks++;
        if (overrun_err !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b expected 1", overrun_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   lat;
        exp_t e;
        for (int i = 0; i < NN4; i++) cur[i] = W'({$urandom(), $urandom()});
        mute = 1'b1;
        send_frame(1'b1);
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== NN4 + WL + 1) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", lat, NN4 + WL + 1);
        end
        checks++;
        if (result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL timeout_result: class=%h to=%b expected class=%h to=%b",
                     result_class, timeout_err, e.cls, e.to);
        end
        tick();
        mute = 1'b0;
        for (int i = 0; i < NN4; i++) cur[i] = W'((NN4 - i) * 3 + ((i == 6) ? 40 : 0));
        send_frame(1'b0);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0 after accept", timeout_err);
        end
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat == 0 || result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL after_timeout_result: lat=%0d class=%h to=%b expected class=%h to=%b",
                     lat, result_class, timeout_err, e.cls, e.to);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   base_start;
        int   base_clear;
        logic hit;
        exp_t e;
        for (int i = 0; i < NN4; i++) cur[i] = W'(i * 11 + 1);
        base_start = n_start;
        send_frame(1'b0);
        hit = 1'b0;
        for (int c = 0; c < BUDGET && !hit; c++) begin
            tick();
            hit = mf_if.start_maxfinder && (n_start - base_start == 6);
        end
        checks++;
        if (!hit || mf_if.input_data !== cur[5]) begin
            errors++;
            $display("FAIL reach_cnt5: hit=%b data=%h expected 1 %h", hit, mf_if.input_data, cur[5]);
        end
        reset = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({busy, result_valid, result_class, timeout_err, overrun_err,
             mf_if.max_finder_reset_allowed, mf_if.start_maxfinder} !== 10'h000 || mf_if.input_data !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b valid=%b class=%h to=%b ov=%b clr=%b start=%b data=%h expected all 0",
                     busy, result_valid, result_class, timeout_err, overrun_err,
                     mf_if.max_finder_reset_allowed, mf_if.start_maxfinder, mf_if.input_data);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < NN4; i++) cur[i] = W'((i == 2) ? 900 : i);
        base_clear = n_clear;
        send_frame(1'b0);
        checks++;
        if (mf_if.max_finder_reset_allowed !== 1'b1 || n_clear - base_clear !== 1) begin
            errors++;
            $display("FAIL post_reset_clear: clr=%b pulses=%0d expected 1 1",
                     mf_if.max_finder_reset_allowed, n_clear - base_clear);
        end
        wait_result(lat);
        e = sb.pop_front();
        checks++;
        if (lat == 0 || result_class !== e.cls || timeout_err !== e.to) begin
            errors++;
            $display("FAIL post_reset_result: lat=%0d class=%h to=%b expected class=%h to=%b",
                     lat, result_class, timeout_err, e.cls, e.to);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   base_clear;
        int   base_start;
        exp_t e;
        base_clear = n_clear;
        base_start = n_start;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NN4; i++) cur[i] = W'({$urandom(), $urandom()});
            send_frame(1'b0);
            wait_result(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== NN4 + 2 || result_class !== e.cls || timeout_err !== e.to) begin
                errors++;
                $display("FAIL b2b_frame%0d: lat=%0d class=%h to=%b expected lat=%0d class=%h to=%b",
                         f, lat, result_class, timeout_err, NN4 + 2, e.cls, e.to);
            end
            tick();
        end
        checks++;
        if (n_clear - base_clear !== 2 || n_start - base_start !== 2 * NN4) begin
            errors++;
            $display("FAIL b2b_pulses: clear=%0d start=%0d expected 2 %0d",
                     n_clear - base_clear, n_start - base_start, 2 * NN4);
        end
        checks++;
        if (overrun_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b expected 0", overrun_err);
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_order();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
